risc_instr_feeder: RTL and testbench

RISC_INSTR_FEEDER -- requirements
Module: risc_instr_feeder

---
 rtl/risc_instr_feeder.sv | 117 +++++++++++
 tb/tb_risc_instr_feeder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/risc_instr_feeder.sv
// rtl/risc_instr_feeder.sv - program store that loads instructions and streams them to a core
module risc_instr_feeder #(
    parameter int IW    = 4,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          load_valid,
    input  logic [IW-1:0] load_data,
    input  logic          load_last,
    output logic          load_ready,
    input  logic          start,
    input  logic          stall,
    output logic [IW-1:0] instr,
    output logic          instr_valid,
    output logic          busy,
    output logic          done,
    output logic [4:0]    length
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LOADED, S_RUN, S_DONE} state_t;

    state_t        state;
    logic [IW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_next;
    logic [4:0]    length_inc;
    logic          load_fire;
    logic          last_read;

    // clear outranks a coincident beat, so the beat never reaches the store
    assign load_fire  = load_valid && load_ready && !clear;
    assign length_inc = length + 5'd1;
    assign rd_next    = rd_ptr + AW'(1);
    assign last_read  = (5'(rd_ptr) + 5'd1) == length;

    always_ff @(posedge clk) begin
        if (load_fire) begin
            mem[wr_ptr] <= load_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            length      <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            load_ready  <= 1'b1;
        end else if (clear) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            length      <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            load_ready  <= 1'b1;
        end else begin
            case (state)
                S_IDLE, S_LOAD: begin
                    if (load_fire) begin
                        wr_ptr <= wr_ptr + AW'(1);
                        length <= length_inc;
                        if (load_last || (length_inc == 5'(DEPTH))) begin
                            state      <= S_LOADED;
                            load_ready <= 1'b0;
                        end else begin
                            state <= S_LOAD;
                        end
                    end
                end
                S_LOADED: begin
                    if (start) begin
                        state       <= S_RUN;
                        rd_ptr      <= '0;
                        instr       <= mem[0];
                        instr_valid <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (!stall) begin
                        if (last_read) begin
                            state       <= S_DONE;
                            instr       <= '0;
                            instr_valid <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                        end else begin
                            rd_ptr <= rd_next;
                            instr  <= mem[rd_next];
                        end
                    end
                end
                S_DONE: begin
                    state <= S_LOADED;
                    done  <= 1'b0;
                end
                default: begin
                    state      <= S_IDLE;
                    load_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_risc_instr_feeder.sv
// tb/tb_risc_instr_feeder.sv - scoreboard bench for risc_instr_feeder
module tb_risc_instr_feeder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       load_valid = 1'b0;
    logic [3:0] load_data = 4'h0;
    logic       load_last = 1'b0;
    logic       load_ready;
    logic       start = 1'b0;
    logic       stall = 1'b0;
    logic [3:0] instr;
    logic       instr_valid;
    logic       busy;
    logic       done;
    logic [4:0] length;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int done_cnt = 0;

    logic [3:0] exp_q[$];
    logic [3:0] mon_exp;
    logic [3:0] prog[16];
    int         prog_len = 0;
    bit         loaded = 1'b0;

    risc_instr_feeder #(.IW(4), .DEPTH(16)) dut (
        .clk(clk),
        .reset(reset),
        .clear(clear),
        .load_valid(load_valid),
        .load_data(load_data),
        .load_last(load_last),
        .load_ready(load_ready),
        .start(start),
        .stall(stall),
        .instr(instr),
        .instr_valid(instr_valid),
        .busy(busy),
        .done(done),
        .length(length)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (instr_valid) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                check("extra_instr", 1, 0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("instr", instr, mon_exp);
            end
        end else if (!reset) begin
            check("idle_instr", instr, 0);
        end
        if (done) done_cnt++;
    end

    task automatic load_beat(input logic [3:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        @(posedge clk); #1;
        load_valid = 1'b0;
        load_last  = 1'b0;
        if (!loaded) begin
            prog[prog_len] = d;
            prog_len++;
            if (last || prog_len == 16) loaded = 1'b1;
        end
    endtask

    task automatic run_prog(input int stall_at, input int stall_len, input bit restart_mid);
        int v0;
        int d0;
        int n;
        for (int k = 0; k < prog_len; k++) begin
            exp_q.push_back(prog[k]);
            if (k == stall_at) repeat (stall_len) exp_q.push_back(prog[k]);
        end
        v0 = valid_cnt;
        d0 = done_cnt;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("latency", instr_valid, 1);
        n = 0;
        while (done_cnt == d0 && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (n == stall_at) stall = 1'b1;
            if (n == stall_at + stall_len) stall = 1'b0;
            if (restart_mid) start = (n == 1);
        end
        start = 1'b0;
        stall = 1'b0;
        check("timeout", n < 100, 1);
        @(negedge clk);
        check("done_width", done, 0);
        check("run_valid", valid_cnt - v0, prog_len + ((stall_at >= 0) ? stall_len : 0));
        check("run_done", done_cnt - d0, 1);
        check("busy_after", busy, 0);
        check("ready_after", load_ready, 0);
        check("len_after", length, prog_len);
        check("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int v0;
        int d0;
        repeat (3) @(negedge clk);
        check("rst_instr", instr, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", load_ready, 1);
        check("rst_len", length, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        load_beat(4'h3, 1'b0);
        load_beat(4'h5, 1'b0);
        load_beat(4'hA, 1'b1);
        @(negedge clk);
        check("len3", length, 3);
        check("ready_loaded", load_ready, 0);
        run_prog(-1, 0, 1'b0);
        run_prog(-1, 0, 1'b0);

        run_prog(-1, 0, 1'b1);
        v0 = valid_cnt;
        repeat (4) @(negedge clk);
        check("no_extend", valid_cnt - v0, 0);

        run_prog(1, 2, 1'b0);

        @(posedge clk); #1;
        clear = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        start = 1'b0;
        prog_len = 0;
        loaded = 1'b0;
        v0 = valid_cnt;
        @(negedge clk);
        check("clr_len", length, 0);
        check("clr_ready", load_ready, 1);
        repeat (3) @(negedge clk);
        check("clr_no_run", valid_cnt - v0, 0);

        @(posedge clk); #1;
        clear = 1'b1;
        load_valid = 1'b1;
        load_data = 4'h7;
        @(posedge clk); #1;
        clear = 1'b0;
        load_valid = 1'b0;
        @(negedge clk);
        check("clr_beat_len", length, 0);

        for (int i = 0; i < 16; i++) load_beat(4'(i), 1'b0);
        @(negedge clk);
        check("len16", length, 16);
        check("ready16", load_ready, 0);
        load_beat(4'h9, 1'b0);
        @(negedge clk);
        check("len16_hold", length, 16);
        run_prog(-1, 0, 1'b0);

        for (int k = 0; k < prog_len; k++) exp_q.push_back(prog[k]);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        #2 reset = 1'b1;
        #1;
        check("arst_valid", instr_valid, 0);
        check("arst_ready", load_ready, 1);
        check("arst_len", length, 0);
        check("arst_busy", busy, 0);
        exp_q.delete();
        prog_len = 0;
        loaded = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("arst_no_done", done_cnt - d0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
